sequenciador_leds: RTL and testbench
====================================

# sequenciador_leds

- Playback controller for the memory-game datapath.
- On command, it walks the stored sequence from address 0 to a given last address and shows each 4-bit item on `leds` for a timed on/off interval.
- On a separate command, it blinks all LEDs a fixed number of times as win/lose feedback.
- It sits between `unidade_controle`, which issues the commands, and the sequence memory/LED outputs in `fluxo_dados`. It replaces the discrete LedsOn/LedsOff/PiscaLeds counter handshakes.

## Interface
- `ADDR_W`, 4: sequence address width (up to 16 items).
- `T_ON`, 1000: cycles an item is lit at nivel=0. Must be even and ≥2.
- `T_OFF`, 500: dark cycles after each item at nivel=0. Must be even and ≥2.
- `T_PISCA`, 250: on time and off time of each feedback blink. Must be ≥1.
- `N_PISCA`, 3: number of feedback blinks. Must be ≥1.
- `clock` in 1: single clock; everything updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `iniciar` in 1: start sequence playback. Level-sampled.
- `piscar` in 1: start feedback blink. Level-sampled.
- `nivel` in 1: 1 halves the `T_ON`/`T_OFF` durations.
- `tamanho` in ADDR_W: last address to play; it plays `tamanho+1` items.
- `dado_mem` in 4: memory data at `endereco`, combinational read.
- `endereco` out ADDR_W: memory address.
- `leds` out 4: LED drive.
- `ocupado` out 1: block is busy.
- `fim` out 1: one-cycle completion pulse.
- `db_estado` out 4: state code, for debug.

## Operation
States and their codes:
- OCIOSO 0: leds=0, endereco=0.
  - `iniciar`=1 → LE. Latch `tamanho` and `nivel`; clear endereco.
  - else `piscar`=1 → PISCA_ON. Load blink count.
  - `iniciar` wins when both are high.
- LE 1: register `dado_mem` into the item register; load the timer with on-duration → ACESO.
- ACESO 2: leds = item register. Timer done → APAGADO, loading the timer with off-duration.
- APAGADO 3: leds=0. Timer done:
  - endereco==latched tamanho → FIM;
  - else endereco+1 → LE.
- PISCA_ON 4: leds=4'b1111 for `T_PISCA` cycles → PISCA_OFF.
- PISCA_OFF 5: leds=0 for `T_PISCA` cycles, then decrement the blink count.
  - count reaches 0 → FIM;
  - else → PISCA_ON.
- FIM 6: `fim`=1 and leds=0 for exactly one cycle → OCIOSO.
- Unused codes → OCIOSO.

Rules:
- Durations: on = nivel_latched ? T_ON>>1 : T_ON; off is the same with T_OFF. Widths come from `$clog2(T_ON+1)` etc. No wrap: endereco never increments past the latched tamanho.
- `ocupado` = 1 in LE, ACESO, APAGADO, PISCA_ON, PISCA_OFF; 0 in OCIOSO and FIM.
- Commands are accepted only in OCIOSO. Commands in any other state, FIM included, are ignored, not queued.
- Changes to `tamanho` or `nivel` mid-operation have no effect.
- Reset, at any time including mid-playback, on the next edge forces:
  - state OCIOSO;
  - leds=0, endereco=0;
  - fim=0, ocupado=0;
  - timer, blink count and item register = 0.

## Timing
- `iniciar` sampled high at edge k → LE during cycle k..k+1, ocupado=1 from edge k.
- Each item takes 1 (LE) + on + off cycles.
- For tamanho=n, FIM occupies the cycle starting at edge k+(n+1)(1+on+off). The block is in OCIOSO one edge later.
- Blink: `piscar` sampled high at edge k → FIM at edge k+2·T_PISCA·N_PISCA.
- `leds` and `ocupado` are registered or state-decoded Moore outputs. There is no combinational path from inputs to outputs.
- `endereco` is valid in LE. `dado_mem` is sampled at the end of LE.

## Structure
- Package `neurosync_pkg` holds the state enum/localparams and their db_estado codes (0–6), shared with `unidade_controle` debug decoding.
- One sub-module, `temporizador`: a load/count-down timer.
  - Inputs: `clock`, `reset`, `carrega`, `valor`.
  - Output: `fim_t`, high in the last counted cycle.
  - Used for both the LED and blink durations.
- The blink counter and endereco counter are inline.

## Test plan
Parameters for all scenarios: T_ON=4, T_OFF=2, T_PISCA=2, N_PISCA=3.
- Playback: memory {0001,0010,0100}, tamanho=2, nivel=0, iniciar pulse at edge k.
  - leds show 0001 ×4, 0000 ×2, then 0010 ×4, 0000 ×2, then 0100 ×4, 0000 ×2.
  - endereco steps 0,1,2; fim high only in the cycle from edge k+21.
- Same playback with nivel=1: each item lit 2 cycles, dark 1 cycle; fim in the cycle from edge k+12.
- Blink: piscar pulse → 1111,1111,0000,0000 repeated 3×; fim in the cycle from edge k+12; endereco stays 0.
- `iniciar` and `piscar` high together → playback path taken. `iniciar` re-pulsed during ACESO and during FIM → ignored; exactly one fim.
- Reset asserted in the 2nd cycle of ACESO for item 1 → next edge gives leds=0, endereco=0, ocupado=0, db_estado=0. A fresh `iniciar` then replays from item 0.
- tamanho=0 → single item played; fim after 7 cycles; endereco never leaves 0.

Source files
------------

// File: rtl/neurosync_pkg.sv
// rtl/neurosync_pkg.sv - state codes and helpers shared by the LED playback datapath
package neurosync_pkg;

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    LE        = 4'd1,
    ACESO     = 4'd2,
    APAGADO   = 4'd3,
    PISCA_ON  = 4'd4,
    PISCA_OFF = 4'd5,
    FIM       = 4'd6
  } estado_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sequenciador_leds_temporizador.sv
// rtl/sequenciador_leds_temporizador.sv - load/count-down timer, fim_t in the last counted cycle
module temporizador #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic [W-1:0] valor,
  output logic         fim_t
);

  logic [W-1:0] r_cnt;

  // A load of N gives N counted cycles; a reload wins over the last count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (carrega) begin
      r_cnt <= valor;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign fim_t = (r_cnt == W'(1));

endmodule

// File: rtl/sequenciador_leds.sv
// rtl/sequenciador_leds.sv - sequence playback and win/lose blink controller for the LEDs
module sequenciador_leds
  import neurosync_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int T_ON    = 1000,
  parameter int T_OFF   = 500,
  parameter int T_PISCA = 250,
  parameter int N_PISCA = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              piscar,
  input  logic              nivel,
  input  logic [ADDR_W-1:0] tamanho,
  input  logic [3:0]        dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              ocupado,
  output logic              fim,
  output logic [3:0]        db_estado
);

  localparam int TW = max3($clog2(T_ON + 1), $clog2(T_OFF + 1), $clog2(T_PISCA + 1));
  localparam int CW = $clog2(N_PISCA + 1);

  estado_t           r_estado;
  estado_t           w_prox;
  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_tamanho;
  logic              r_nivel;
  logic [3:0]        r_item;
  logic [CW-1:0]     r_conta;

  logic              w_carrega;
  logic [TW-1:0]     w_valor;
  logic              w_fim_t;
  logic [TW-1:0]     w_dur_on;
  logic [TW-1:0]     w_dur_off;
  logic [TW-1:0]     w_dur_pisca;

  assign w_dur_on    = r_nivel ? TW'(T_ON / 2)  : TW'(T_ON);
  assign w_dur_off   = r_nivel ? TW'(T_OFF / 2) : TW'(T_OFF);
  assign w_dur_pisca = TW'(T_PISCA);

  temporizador #(
    .W(TW)
  ) u_temporizador (
    .clock  (clock),
    .reset  (reset),
    .carrega(w_carrega),
    .valor  (w_valor),
    .fim_t  (w_fim_t)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  // The timer is loaded on the edge that enters each timed state.
  always_comb begin
    w_prox    = r_estado;
    w_carrega = 1'b0;
    w_valor   = '0;
    case (r_estado)
      OCIOSO: begin
        if (iniciar) begin
          w_prox = LE;
        end else if (piscar) begin
          w_prox    = PISCA_ON;
          w_carrega = 1'b1;
          w_valor   = w_dur_pisca;
        end
      end
      LE: begin
        w_prox    = ACESO;
        w_carrega = 1'b1;
        w_valor   = w_dur_on;
      end
      ACESO: begin
        if (w_fim_t) begin
          w_prox    = APAGADO;
          w_carrega = 1'b1;
          w_valor   = w_dur_off;
        end
      end
      APAGADO: begin
        if (w_fim_t) begin
          w_prox = (r_endereco == r_tamanho) ? FIM : LE;
        end
      end
      PISCA_ON: begin
        if (w_fim_t) begin
          w_prox    = PISCA_OFF;
          w_carrega = 1'b1;
          w_valor   = w_dur_pisca;
        end
      end
      PISCA_OFF: begin
        if (w_fim_t) begin
          if (r_conta == CW'(1)) begin
            w_prox = FIM;
          end else begin
            w_prox    = PISCA_ON;
            w_carrega = 1'b1;
            w_valor   = w_dur_pisca;
          end
        end
      end
      FIM:     w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  // Parameters of a run are captured once, so later input changes cannot disturb it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_endereco <= '0;
      r_tamanho  <= '0;
      r_nivel    <= 1'b0;
      r_item     <= 4'd0;
      r_conta    <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (iniciar) begin
            r_tamanho  <= tamanho;
            r_nivel    <= nivel;
            r_endereco <= '0;
          end else if (piscar) begin
            r_conta <= CW'(N_PISCA);
          end
        end
        LE: r_item <= dado_mem;
        APAGADO: begin
          if (w_fim_t && (r_endereco != r_tamanho)) begin
            r_endereco <= r_endereco + ADDR_W'(1);
          end
        end
        PISCA_OFF: begin
          if (w_fim_t) begin
            r_conta <= r_conta - CW'(1);
          end
        end
        FIM:     r_endereco <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    leds    = 4'd0;
    ocupado = 1'b0;
    fim     = 1'b0;
    case (r_estado)
      LE:        ocupado = 1'b1;
      ACESO: begin
        leds    = r_item;
        ocupado = 1'b1;
      end
      APAGADO:   ocupado = 1'b1;
      PISCA_ON: begin
        leds    = 4'b1111;
        ocupado = 1'b1;
      end
      PISCA_OFF: ocupado = 1'b1;
      FIM:       fim = 1'b1;
      default: ;
    endcase
  end

  assign endereco  = r_endereco;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_sequenciador_leds.sv
// tb/tb_sequenciador_leds.sv - scoreboard bench for sequenciador_leds playback, blink and reset
module tb_sequenciador_leds;

  localparam int TB_T_ON    = 4;
  localparam int TB_T_OFF   = 2;
  localparam int TB_T_PISCA = 2;
  localparam int TB_N_PISCA = 3;

  typedef struct {
    logic [3:0] leds;
    logic [3:0] ende;
    logic       oc;
    logic       fim;
    logic [3:0] st;
    bit         chk_e;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       piscar = 1'b0;
  logic       nivel = 1'b0;
  logic [3:0] tamanho = 4'd0;
  logic [3:0] dado_mem;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       fim;
  logic [3:0] db_estado;

  logic [3:0] mem [16];
  exp_t       sb [$];
  exp_t       cur;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  assign dado_mem = mem[endereco];

  sequenciador_leds #(
    .ADDR_W (4),
    .T_ON   (TB_T_ON),
    .T_OFF  (TB_T_OFF),
    .T_PISCA(TB_T_PISCA),
    .N_PISCA(TB_N_PISCA)
  ) dut (
    .clock    (clk),
    .reset    (reset),
    .iniciar  (iniciar),
    .piscar   (piscar),
    .nivel    (nivel),
    .tamanho  (tamanho),
    .dado_mem (dado_mem),
    .endereco (endereco),
    .leds     (leds),
    .ocupado  (ocupado),
    .fim      (fim),
    .db_estado(db_estado)
  );

  task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] l, input int e, input logic oc,
                              input logic f, input logic [3:0] st, input bit ce);
    exp_t x;
    x.leds  = l;
    x.ende  = 4'(e);
    x.oc    = oc;
    x.fim   = f;
    x.st    = st;
    x.chk_e = ce;
    return x;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk_val("leds", 16'(leds), 16'(cur.leds));
      chk_val("ocupado", 16'(ocupado), 16'(cur.oc));
      chk_val("fim", 16'(fim), 16'(cur.fim));
      chk_val("db_estado", 16'(db_estado), 16'(cur.st));
      if (cur.chk_e) chk_val("endereco", 16'(endereco), 16'(cur.ende));
    end
  end

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 200) begin
      @(posedge clk);
      b++;
    end
    chk_val("drain_left", 16'(sb.size()), 16'd0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic do_play(input int n, input bit niv, input bit both, input bit rep, input int rst_at);
    int   on_c;
    int   off_c;
    int   tot;
    int   last;
    exp_t s [$];
    drain();
    on_c  = niv ? TB_T_ON / 2 : TB_T_ON;
    off_c = niv ? TB_T_OFF / 2 : TB_T_OFF;
    tot   = (n + 1) * (1 + on_c + off_c);
    sb.push_back(mk(4'd0, 0, 1'b0, 1'b0, 4'd0, 1'b1));
    for (int i = 0; i <= n; i++) begin
      s.push_back(mk(4'd0, i, 1'b1, 1'b0, 4'd1, 1'b1));
      for (int c = 0; c < on_c; c++) s.push_back(mk(mem[i], i, 1'b1, 1'b0, 4'd2, 1'b1));
      for (int c = 0; c < off_c; c++) s.push_back(mk(4'd0, i, 1'b1, 1'b0, 4'd3, 1'b1));
    end
    s.push_back(mk(4'd0, n, 1'b0, 1'b1, 4'd6, 1'b0));
    if (rst_at >= 0) while (s.size() > rst_at) void'(s.pop_back());
    foreach (s[i]) sb.push_back(s[i]);
    sb.push_back(mk(4'd0, 0, 1'b0, 1'b0, 4'd0, 1'b1));
    last    = s.size();
    tamanho = 4'(n);
    nivel   = niv;
    for (int j = 0; j <= last; j++) begin
      iniciar = (j == 0) || (rep && (j == 3 || j == tot + 1));
      piscar  = both && (j == 0);
      reset   = (rst_at >= 0) && (j == rst_at);
      if (j > 0) begin
        tamanho = 4'($urandom_range(0, 15));
        nivel   = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
    end
    iniciar = 1'b0;
    piscar  = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic do_blink();
    int tot;
    drain();
    tot = 2 * TB_T_PISCA * TB_N_PISCA;
    sb.push_back(mk(4'd0, 0, 1'b0, 1'b0, 4'd0, 1'b1));
    for (int b = 0; b < TB_N_PISCA; b++) begin
      for (int c = 0; c < TB_T_PISCA; c++) sb.push_back(mk(4'b1111, 0, 1'b1, 1'b0, 4'd4, 1'b1));
      for (int c = 0; c < TB_T_PISCA; c++) sb.push_back(mk(4'd0, 0, 1'b1, 1'b0, 4'd5, 1'b1));
    end
    sb.push_back(mk(4'd0, 0, 1'b0, 1'b1, 4'd6, 1'b1));
    sb.push_back(mk(4'd0, 0, 1'b0, 1'b0, 4'd0, 1'b1));
    for (int j = 0; j <= tot + 1; j++) begin
      piscar  = (j == 0) || (j == 5);
      tamanho = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    piscar = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (mem[i]) mem[i] = 4'(i * 3 + 5);
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b0100;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(mk(4'd0, 0, 1'b0, 1'b0, 4'd0, 1'b1));
    @(posedge clk);
    #1;
    reset = 1'b0;

    do_play(2, 1'b0, 1'b0, 1'b0, -1);
    do_play(2, 1'b1, 1'b0, 1'b0, -1);
    do_blink();
    do_play(2, 1'b0, 1'b1, 1'b1, -1);
    do_play(2, 1'b0, 1'b0, 1'b0, 10);
    do_play(2, 1'b0, 1'b0, 1'b0, -1);
    do_play(0, 1'b0, 1'b0, 1'b0, -1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
